// File: rtl/sa_feed_pkg.sv
// -----------------------------------------------------------------------------
// sa_feed_pkg
// Shared definitions for the systolic-array operand feeder:
//   - LEN_W    : width of the beat-length / beat-count fields
//   - state_t  : feeder FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - clog2()  : address-width helper usable in parameter expressions
// Optional feature macro used by the feeder: SA_FEED_SKEW_EN.
// -----------------------------------------------------------------------------
package sa_feed_pkg;

   localparam int LEN_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Ceiling log2, never less than 1 so a 1-word memory still gets an address bit.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/sa_skew_line.sv
// -----------------------------------------------------------------------------
// sa_skew_line
// Stall-gated shift register delaying one operand lane by STAGES cycles.
// STAGES = 0 degenerates to a plain wire.
// Ports:
//   CLK   in  clock (rising edge)
//   RST   in  asynchronous active-low reset, clears the delay stages
//   stall in  1 = hold all stages
//   din   in  WIDTH lane input
//   dout  out WIDTH lane output, din delayed by STAGES shifts
// -----------------------------------------------------------------------------
module sa_skew_line
   import sa_feed_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             stall,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (STAGES == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, RST, stall};
      assign dout        = din;
   end else begin : g_shift
      logic [WIDTH-1:0] sr_q [STAGES];
      logic [WIDTH-1:0] sr_d [STAGES];

      always_comb begin
         for (int i = 0; i < STAGES; i++) begin
            sr_d[i] = sr_q[i];
         end
         if (!stall) begin
            sr_d[0] = din;
            for (int i = 1; i < STAGES; i++) begin
               sr_d[i] = sr_q[i-1];
            end
         end
      end

      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            for (int i = 0; i < STAGES; i++) begin
               sr_q[i] <= '0;
            end
         end else begin
            for (int i = 0; i < STAGES; i++) begin
               sr_q[i] <= sr_d[i];
            end
         end
      end

      assign dout = sr_q[STAGES-1];
   end

endmodule

// File: rtl/sa_operand_feeder.sv
// -----------------------------------------------------------------------------
// sa_operand_feeder
// Operand streamer for an HPE x VPE systolic array. Holds A and B operand
// memories and, after start, streams len beats: HPE consecutive A words on AA
// and VPE consecutive B words on BB per beat, wrapping past DEPTH-1.
// Macro SA_FEED_SKEW_EN: delays lane n by n cycles (diagonal wavefront) and
// adds a DRAIN phase of max(HPE,VPE)-1 cycles; undefined = aligned lanes.
// Ports:
//   CLK, RST          clock, asynchronous active-low reset
//   wr_en_a/wr_en_b   write wr_data at wr_addr into A / B memory (any state)
//   start             start request, accepted only in IDLE
//   base_a/base_b/len stream setup, sampled at the accepting edge
//   stall             hold the stream (array back-pressure)
//   AA, BB            lane-packed operand outputs, 0 outside valid beats
//   out_valid         AA/BB carry a beat
//   busy              FSM not in IDLE
//   done              one-cycle completion pulse
// -----------------------------------------------------------------------------
module sa_operand_feeder
   import sa_feed_pkg::*;
#(
   parameter  int WIDTH  = 32,
   parameter  int HPE    = 8,
   parameter  int VPE    = 8,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = clog2(DEPTH)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               wr_en_a,
   input  logic               wr_en_b,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_a,
   input  logic [ADDR_W-1:0]  base_b,
   input  logic [LEN_W-1:0]   len,
   input  logic               stall,
   output logic [WIDTH*HPE-1:0] AA,
   output logic [WIDTH*VPE-1:0] BB,
   output logic               out_valid,
   output logic               busy,
   output logic               done
);

   localparam int SKEW_N = ((HPE > VPE) ? HPE : VPE) - 1;
`ifdef SA_FEED_SKEW_EN
   localparam bit SKEW_EN = 1'b1;
`else
   localparam bit SKEW_EN = 1'b0;
`endif

   // NOTE: operand memories carry no reset; only control and output registers do.
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];

   always_ff @(posedge CLK) begin
      if (wr_en_a) mem_a[wr_addr] <= wr_data;
      if (wr_en_b) mem_b[wr_addr] <= wr_data;
   end

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    ptr_a_q, ptr_a_d;
   logic [ADDR_W-1:0]    ptr_b_q, ptr_b_d;
   logic [LEN_W-1:0]     cnt_q, cnt_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     drain_q, drain_d;
   logic                 valid_q, valid_d;
   logic [WIDTH*HPE-1:0] aa_q, aa_d;
   logic [WIDTH*VPE-1:0] bb_q, bb_d;
   logic                 emit;
   logic [ADDR_W-1:0]    rd_a, rd_b;

   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                   input int unsigned ofs);
      int unsigned sum;
      sum = 32'(base) + ofs;
      return ADDR_W'(sum % unsigned'(DEPTH));
   endfunction

   always_comb begin
      // NOTE: every _d gets a hold default first so no path can infer a latch.
      state_d = state_q;
      ptr_a_d = ptr_a_q;
      ptr_b_d = ptr_b_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      drain_d = drain_q;
      valid_d = valid_q;
      aa_d    = aa_q;
      bb_d    = bb_q;
      emit    = 1'b0;
      rd_a    = ptr_a_q;
      rd_b    = ptr_b_q;

      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            aa_d    = '0;
            bb_d    = '0;
            if (start) begin
               len_d = len;
               cnt_d = '0;
               if (len == '0) begin
                  state_d = ST_DONE;
               end else begin
                  // The first beat is read straight from the base addresses so it
                  // is registered on the accepting edge.
                  state_d = ST_RUN;
                  emit    = 1'b1;
                  rd_a    = base_a;
                  rd_b    = base_b;
               end
            end
         end
         ST_RUN: begin
            if (!stall) begin
               if (cnt_q == len_q) begin
                  // Last beat has been on the outputs for its cycle; retire it.
                  valid_d = 1'b0;
                  aa_d    = '0;
                  bb_d    = '0;
                  drain_d = '0;
                  state_d = (SKEW_EN && (SKEW_N > 0)) ? ST_DRAIN : ST_DONE;
               end else begin
                  emit = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (!stall) begin
               if (drain_q == LEN_W'(SKEW_N - 1)) state_d = ST_DONE;
               else                               drain_d = drain_q + 1'b1;
            end
         end
         default: begin
            // DONE lasts exactly one cycle regardless of stall.
            state_d = ST_IDLE;
         end
      endcase

      if (emit) begin
         valid_d = 1'b1;
         cnt_d   = cnt_d + 1'b1;
         for (int n = 0; n < HPE; n++) begin
            aa_d[n*WIDTH +: WIDTH] = mem_a[wrap_addr(rd_a, unsigned'(n))];
         end
         for (int m = 0; m < VPE; m++) begin
            bb_d[m*WIDTH +: WIDTH] = mem_b[wrap_addr(rd_b, unsigned'(m))];
         end
         ptr_a_d = wrap_addr(rd_a, unsigned'(HPE));
         ptr_b_d = wrap_addr(rd_b, unsigned'(VPE));
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         ptr_a_q <= '0;
         ptr_b_q <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         drain_q <= '0;
         valid_q <= 1'b0;
         aa_q    <= '0;
         bb_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_a_q <= ptr_a_d;
         ptr_b_q <= ptr_b_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         drain_q <= drain_d;
         valid_q <= valid_d;
         aa_q    <= aa_d;
         bb_q    <= bb_d;
      end
   end

`ifdef SA_FEED_SKEW_EN
   for (genvar n = 0; n < HPE; n++) begin : g_skew_a
      sa_skew_line #(.WIDTH(WIDTH), .STAGES(n)) u_line (
         .CLK   (CLK),
         .RST   (RST),
         .stall (stall),
         .din   (aa_q[n*WIDTH +: WIDTH]),
         .dout  (AA[n*WIDTH +: WIDTH])
      );
   end
   for (genvar m = 0; m < VPE; m++) begin : g_skew_b
      sa_skew_line #(.WIDTH(WIDTH), .STAGES(m)) u_line (
         .CLK   (CLK),
         .RST   (RST),
         .stall (stall),
         .din   (bb_q[m*WIDTH +: WIDTH]),
         .dout  (BB[m*WIDTH +: WIDTH])
      );
   end
`else
   assign AA = aa_q;
   assign BB = bb_q;
`endif

   // During DRAIN the delayed lanes are still delivering the tail of the wavefront.
   assign out_valid = valid_q | (state_q == ST_DRAIN);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);

endmodule
